// File: rtl/mem_responder.sv
// Word-addressed memory target behind a valid/ready request/response pair.
// One transaction in flight; the response appears a fixed LATENCY cycles after acceptance.
module mem_responder #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int DEPTH_LOG2 = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h8000_0000),
   parameter int LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_wen,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(1) << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

   stateT                  state;
   logic [3:0]             count;
   logic [DATA_WIDTH-1:0]  pendData;
   logic                   pendErr;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [ADDR_WIDTH-1:0]  offset;
   logic [ADDR_WIDTH-1:0]  wordOff;
   logic [DEPTH_LOG2-1:0]  wordIdx;
   logic                   inRange;
   logic                   accept;
   logic [DATA_WIDTH-1:0]  accData;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   // The lower-bound test guards the subtraction, so a below-base address can never alias into storage.
   always_comb begin
      offset  = req_addr - BASE_ADDR;
      wordOff = offset >> 3;
      inRange = (req_addr >= BASE_ADDR) && (wordOff < DEPTH_WORDS);
      wordIdx = wordOff[DEPTH_LOG2-1:0];
      accData = (inRange && !req_wen) ? mem[wordIdx] : '0;
   end

   always_ff @(posedge clk) begin
      if (accept && req_wen && inRange) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (req_wmask[i]) mem[wordIdx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   // Read data is snapshotted at acceptance and only presented on the response port in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         pendData  <= '0;
         pendErr   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pendData <= accData;
                  pendErr  <= !inRange;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= accData;
                     rsp_err   <= !inRange;
                  end else begin
                     state <= BUSY;
                     count <= 4'(LATENCY - 2);
                  end
               end
            end
            BUSY: begin
               if (count == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= pendData;
                  rsp_err   <= pendErr;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data word width in bits (fixed at 64; 8 byte lanes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, request address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12, log2 of storage depth in 64-bit words.
REQ-004 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of word 0 (same value as PC reset vector).
REQ-005 SHALL have parameter LATENCY, default 2, cycles from request handshake to response valid; legal range 1..15.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid  input  1  initiator presents a request.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  byte address; bits [2:0] ignored for word select.
REQ-011 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-012 SHALL have port req_wdata  input  64  write data.
REQ-013 SHALL have port req_wmask  input  8  byte-lane write enables, bit i = byte i.
REQ-014 SHALL have port rsp_valid  output  1  response present.
REQ-015 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-016 SHALL have port rsp_rdata  output  64  read data (0 for writes and errors).
REQ-017 SHALL have port rsp_err  output  1  address out of range.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP; at most one transaction outstanding.
REQ-019 SHALL drive req_ready=1 only in IDLE, and only when rst is low.
REQ-020 SHALL accept a request in cycle c when req_valid && req_ready; all req_* fields captured at that edge.
REQ-021 SHALL flag in range iff BASE_ADDR <= req_addr < BASE_ADDR + 8*2^DEPTH_LOG2 (unsigned compare, no wrap); word index = (req_addr - BASE_ADDR) >> 3.
REQ-022 SHALL, for in-range writes, update byte i of the addressed word with req_wdata[8i+7:8i] for each set req_wmask[i], at the acceptance edge; other bytes unchanged; wmask=0 is a legal no-op write.
REQ-023 SHALL, for out-of-range requests, not modify storage; response rsp_err=1, rsp_rdata=0.
REQ-024 SHALL, for in-range reads, return the full aligned 64-bit word as of the acceptance edge (any earlier write is visible).
REQ-025 SHALL transition IDLE->RESP after acceptance when LATENCY=1, else IDLE->BUSY with a down-counter loaded with LATENCY-2; BUSY->RESP when the counter is 0.
REQ-026 SHALL assert rsp_valid starting exactly in cycle c+LATENCY.
REQ-027 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid && rsp_ready.
REQ-028 SHALL go RESP->IDLE on the response handshake; req_ready is 1 in the following cycle (no same-cycle turnaround), giving peak throughput of one transaction per LATENCY+1 cycles.
REQ-029 SHALL ignore req_valid outside IDLE; rsp_ready while rsp_valid=0 has no effect.
REQ-030 SHALL keep rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-031 SHALL, on rst high (asynchronously), force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-032 SHALL drive req_ready=1 in the first cycle after rst deasserts.
REQ-033 SHALL not reset storage contents; a write accepted before reset mid-transaction remains committed, and its response is dropped.

Verification
REQ-034 Write 64'h1122_3344_5566_7788, mask 8'hFF, to 0x8000_0010, then read 0x8000_0010 -> rsp_err=0, rsp_rdata=64'h1122_3344_5566_7788, rsp_valid in cycle c+2.
REQ-035 Partial write 64'hAAAA_AAAA_AAAA_AAAA, mask 8'h0F, onto the word above, then read -> rsp_rdata=64'h1122_3344_AAAA_AAAA.
REQ-036 Read 0x7FFF_FFF8 and 0x8000_8000 (DEPTH_LOG2=12) -> rsp_err=1, rsp_rdata=0, storage unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, second req_valid ignored; release -> req_ready=1 the next cycle.
REQ-038 Assert rst in BUSY after a write of 64'h55 to 0x8000_0000 -> rsp_valid=0 immediately, req_ready=1 the cycle after release; a subsequent read returns 64'h55.
REQ-039 Repeat REQ-034 with LATENCY=1 and LATENCY=15 -> rsp_valid first in cycle c+1 and c+15 respectively.
